// File: rtl/eth_frame_loop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_loop_pkg
// Description : Shared types and default widths for the frame loop RX/TX
//               blocks and their script-memory arbiter.
//               Contents: arbiter state enum, default width constants and
//               an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_frame_loop_pkg;

    localparam int C_DEF_NUM_MASTERS = 2;
    localparam int C_DEF_ADDR_WIDTH  = 15;
    localparam int C_DEF_AXI_WIDTH   = 32;
    localparam int C_DEF_TIMEOUT     = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches the request
//               vector upward from last_grant+1, wrapping at C_NUM_REQ, and
//               returns the first set position.
// Ports       : req        in  C_NUM_REQ    request vector
//               last_grant in  C_IDX_WIDTH  previously granted index
//               grant      out C_IDX_WIDTH  selected index (0 when !valid)
//               valid      out 1            at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int C_NUM_REQ   = 2,
    parameter int C_IDX_WIDTH = 1
) (
    input  logic [C_NUM_REQ-1:0]   req,
    input  logic [C_IDX_WIDTH-1:0] last_grant,
    output logic [C_IDX_WIDTH-1:0] grant,
    output logic                   valid
);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        // Offset C_NUM_REQ wraps back to last_grant itself, so a lone
        // requester can be granted again.
        for (int k = 1; k <= C_NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % C_NUM_REQ;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = C_IDX_WIDTH'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_frame_loop_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_loop_mem_arbiter
// Description : Shares the frame loop script-memory port between
//               C_NUM_MASTERS requesters. Round-robin, one transaction in
//               flight, registered outputs, watchdog abort on missing ack.
// Ports       : clk, rst_n           clock, synchronous active-low reset
//               s_mem_req/addr/wenable/wdata  packed requester inputs
//               s_mem_rdata/ack/err  shared read data, one-hot ack, timeout
//               m_mem_req/addr/wenable/wdata  memory request (registered)
//               m_mem_rdata/ack      memory response
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_loop_mem_arbiter
    import eth_frame_loop_pkg::*;
#(
    parameter int C_NUM_MASTERS = C_DEF_NUM_MASTERS,
    parameter int C_ADDR_WIDTH  = C_DEF_ADDR_WIDTH,
    parameter int C_AXI_WIDTH   = C_DEF_AXI_WIDTH,
    parameter int C_TIMEOUT     = C_DEF_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [C_NUM_MASTERS-1:0]             s_mem_req,
    input  logic [C_NUM_MASTERS*C_ADDR_WIDTH-1:0] s_mem_addr,
    input  logic [C_NUM_MASTERS-1:0]             s_mem_wenable,
    input  logic [C_NUM_MASTERS*C_AXI_WIDTH-1:0] s_mem_wdata,
    output logic [C_AXI_WIDTH-1:0]               s_mem_rdata,
    output logic [C_NUM_MASTERS-1:0]             s_mem_ack,
    output logic                                 s_mem_err,
    output logic                                 m_mem_req,
    output logic [C_ADDR_WIDTH-1:0]              m_mem_addr,
    output logic                                 m_mem_wenable,
    output logic [C_AXI_WIDTH-1:0]               m_mem_wdata,
    input  logic [C_AXI_WIDTH-1:0]               m_mem_rdata,
    input  logic                                 m_mem_ack
);

    localparam int C_GNT_WIDTH = idx_width(C_NUM_MASTERS);
    localparam int C_CNT_WIDTH = idx_width(C_TIMEOUT);
    localparam logic [C_CNT_WIDTH-1:0] C_CNT_LAST  = C_CNT_WIDTH'(C_TIMEOUT - 1);
    localparam logic [C_GNT_WIDTH-1:0] C_GNT_RESET = C_GNT_WIDTH'(C_NUM_MASTERS - 1);

    state_t                     r_state, w_state_nxt;
    logic [C_GNT_WIDTH-1:0]     r_last_grant, w_last_grant_nxt;
    logic [C_CNT_WIDTH-1:0]     r_count, w_count_nxt;
    logic                       r_m_req, w_m_req_nxt;
    logic [C_ADDR_WIDTH-1:0]    r_m_addr, w_m_addr_nxt;
    logic                       r_m_we, w_m_we_nxt;
    logic [C_AXI_WIDTH-1:0]     r_m_wdata, w_m_wdata_nxt;
    logic [C_AXI_WIDTH-1:0]     r_s_rdata, w_s_rdata_nxt;
    logic [C_NUM_MASTERS-1:0]   r_s_ack, w_s_ack_nxt;
    logic                       r_s_err, w_s_err_nxt;

    logic [C_GNT_WIDTH-1:0]     w_arb_grant;
    logic                       w_arb_valid;
    logic [C_NUM_MASTERS-1:0]   w_ack_onehot;

    rr_arbiter #(
        .C_NUM_REQ   (C_NUM_MASTERS),
        .C_IDX_WIDTH (C_GNT_WIDTH)
    ) u_rr_arbiter (
        .req        (s_mem_req),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant),
        .valid      (w_arb_valid)
    );

    // last_grant doubles as the index of the transaction in flight.
    for (genvar gi = 0; gi < C_NUM_MASTERS; gi++) begin : g_ack_onehot
        assign w_ack_onehot[gi] = (r_last_grant == C_GNT_WIDTH'(gi));
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_count_nxt      = r_count;
        w_m_req_nxt      = r_m_req;
        w_m_addr_nxt     = r_m_addr;
        w_m_we_nxt       = r_m_we;
        w_m_wdata_nxt    = r_m_wdata;
        w_s_rdata_nxt    = r_s_rdata;
        w_s_ack_nxt      = '0;
        w_s_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_m_addr_nxt     = s_mem_addr[int'(w_arb_grant)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                    w_m_we_nxt       = s_mem_wenable[w_arb_grant];
                    w_m_wdata_nxt    = s_mem_wdata[int'(w_arb_grant)*C_AXI_WIDTH +: C_AXI_WIDTH];
                    w_m_req_nxt      = 1'b1;
                    w_last_grant_nxt = w_arb_grant;
                    w_count_nxt      = '0;
                    w_state_nxt      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real ack wins over a watchdog expiry on the same cycle.
                if (m_mem_ack) begin
                    w_s_rdata_nxt = m_mem_rdata;
                    w_s_ack_nxt   = w_ack_onehot;
                    w_m_req_nxt   = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else if (r_count == C_CNT_LAST) begin
                    w_s_rdata_nxt = '0;
                    w_s_ack_nxt   = w_ack_onehot;
                    w_s_err_nxt   = 1'b1;
                    w_m_req_nxt   = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_count_nxt = r_count + C_CNT_WIDTH'(1);
                end
            end
            // Requests are not sampled here, giving the served requester one
            // cycle to drop its request level after the ack.
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= C_GNT_RESET;
            r_count      <= '0;
            r_m_req      <= 1'b0;
            r_m_addr     <= '0;
            r_m_we       <= 1'b0;
            r_m_wdata    <= '0;
            r_s_rdata    <= '0;
            r_s_ack      <= '0;
            r_s_err      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_count      <= w_count_nxt;
            r_m_req      <= w_m_req_nxt;
            r_m_addr     <= w_m_addr_nxt;
            r_m_we       <= w_m_we_nxt;
            r_m_wdata    <= w_m_wdata_nxt;
            r_s_rdata    <= w_s_rdata_nxt;
            r_s_ack      <= w_s_ack_nxt;
            r_s_err      <= w_s_err_nxt;
        end
    end

    assign s_mem_rdata   = r_s_rdata;
    assign s_mem_ack     = r_s_ack;
    assign s_mem_err     = r_s_err;
    assign m_mem_req     = r_m_req;
    assign m_mem_addr    = r_m_addr;
    assign m_mem_wenable = r_m_we;
    assign m_mem_wdata   = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_loop_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_frame_loop_mem_arbiter
// Description : Self-checking bench for eth_frame_loop_mem_arbiter with two
//               requesters and an 8-cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_frame_loop_mem_arbiter;

    localparam int C_N  = 2;
    localparam int C_AW = 15;
    localparam int C_DW = 32;
    localparam int C_TO = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [C_N-1:0]     s_mem_req = '0;
    logic [C_N*C_AW-1:0] s_mem_addr = '0;
    logic [C_N-1:0]     s_mem_wenable = '0;
    logic [C_N*C_DW-1:0] s_mem_wdata = '0;
    logic [C_DW-1:0]    s_mem_rdata;
    logic [C_N-1:0]     s_mem_ack;
    logic               s_mem_err;
    logic               m_mem_req;
    logic [C_AW-1:0]    m_mem_addr;
    logic               m_mem_wenable;
    logic [C_DW-1:0]    m_mem_wdata;
    logic [C_DW-1:0]    m_mem_rdata = '0;
    logic               m_mem_ack = 1'b0;

    typedef struct { logic [C_N-1:0] ack; logic [C_DW-1:0] rdata; logic err; } rsp_t;
    typedef struct { logic [C_AW-1:0] addr; logic we; logic [C_DW-1:0] wdata; } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   grant_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eth_frame_loop_mem_arbiter #(
        .C_NUM_MASTERS (C_N),
        .C_ADDR_WIDTH  (C_AW),
        .C_AXI_WIDTH   (C_DW),
        .C_TIMEOUT     (C_TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_mem_req     (s_mem_req),
        .s_mem_addr    (s_mem_addr),
        .s_mem_wenable (s_mem_wenable),
        .s_mem_wdata   (s_mem_wdata),
        .s_mem_rdata   (s_mem_rdata),
        .s_mem_ack     (s_mem_ack),
        .s_mem_err     (s_mem_err),
        .m_mem_req     (m_mem_req),
        .m_mem_addr    (m_mem_addr),
        .m_mem_wenable (m_mem_wenable),
        .m_mem_wdata   (m_mem_wdata),
        .m_mem_rdata   (m_mem_rdata),
        .m_mem_ack     (m_mem_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mreq(output bit ok);
        int n;
        n = 0;
        while (m_mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        ok = (m_mem_req === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (m_mem_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b need 0", m_mem_req); end
        checks++; if (m_mem_addr !== '0) begin errors++; $display("FAIL reset_m_addr: got %h need 0", m_mem_addr); end
        checks++; if (s_mem_ack !== '0) begin errors++; $display("FAIL reset_s_ack: got %b need 00", s_mem_ack); end
        checks++; if (s_mem_err !== 1'b0) begin errors++; $display("FAIL reset_s_err: got %b need 0", s_mem_err); end
        checks++; if (s_mem_rdata !== '0) begin errors++; $display("FAIL reset_s_rdata: got %h need 0", s_mem_rdata); end
    endtask

    task automatic test_single_read();
        req_t r;
        rsp_t e;
        s_mem_addr[C_AW-1:0] = 15'h0010;
        s_mem_wenable        = 2'b00;
        s_mem_req            = 2'b01;
        req_q.push_back('{addr: 15'h0010, we: 1'b0, wdata: 32'h0});
        rsp_q.push_back('{ack: 2'b01, rdata: 32'hDEADBEEF, err: 1'b0});
        tick();
        checks++; if (m_mem_req !== 1'b1) begin errors++; $display("FAIL rd_latency: m_req got %b need 1", m_mem_req); end
        r = req_q.pop_front();
        checks++; if (m_mem_addr !== r.addr) begin errors++; $display("FAIL rd_addr: got %h need %h", m_mem_addr, r.addr); end
        checks++; if (m_mem_wenable !== r.we) begin errors++; $display("FAIL rd_we: got %b need %b", m_mem_wenable, r.we); end
        tick();
        tick();
        m_mem_ack   = 1'b1;
        m_mem_rdata = 32'hDEADBEEF;
        checks++; if (s_mem_ack !== 2'b00) begin errors++; $display("FAIL rd_early_ack: got %b need 00", s_mem_ack); end
        tick();
        m_mem_ack = 1'b0;
        s_mem_req = 2'b00;
        e = rsp_q.pop_front();
        checks++; if (s_mem_ack !== e.ack) begin errors++; $display("FAIL rd_ack: got %b need %b", s_mem_ack, e.ack); end
        checks++; if (s_mem_rdata !== e.rdata) begin errors++; $display("FAIL rd_data: got %h need %h", s_mem_rdata, e.rdata); end
        checks++; if (s_mem_err !== e.err) begin errors++; $display("FAIL rd_err: got %b need %b", s_mem_err, e.err); end
        checks++; if (m_mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b need 0", m_mem_req); end
        tick();
        checks++; if (s_mem_ack !== 2'b00) begin errors++; $display("FAIL rd_ack_pulse: got %b need 00", s_mem_ack); end
    endtask

    task automatic test_write();
        req_t r;
        rsp_t e;
        bit   ok;
        s_mem_addr[2*C_AW-1:C_AW]  = 15'h2004;
        s_mem_wdata[2*C_DW-1:C_DW] = 32'h12345678;
        s_mem_wenable              = 2'b10;
        s_mem_req                  = 2'b10;
        req_q.push_back('{addr: 15'h2004, we: 1'b1, wdata: 32'h12345678});
        rsp_q.push_back('{ack: 2'b10, rdata: 32'hA5A50001, err: 1'b0});
        wait_mreq(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_req_timeout: got m_req %b need 1", m_mem_req); end
        r = req_q.pop_front();
        // Requester inputs change while BUSY; the latched request must not.
        s_mem_wdata[2*C_DW-1:C_DW] = 32'h0;
        s_mem_addr[2*C_AW-1:C_AW]  = 15'h0;
        s_mem_wenable              = 2'b00;
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_mem_addr !== r.addr) begin errors++; $display("FAIL wr_addr_hold: got %h need %h", m_mem_addr, r.addr); end
            checks++; if (m_mem_wenable !== r.we) begin errors++; $display("FAIL wr_we_hold: got %b need %b", m_mem_wenable, r.we); end
            checks++; if (m_mem_wdata !== r.wdata) begin errors++; $display("FAIL wr_wdata_hold: got %h need %h", m_mem_wdata, r.wdata); end
            tick();
        end
        m_mem_ack   = 1'b1;
        m_mem_rdata = 32'hA5A50001;
        tick();
        m_mem_ack = 1'b0;
        s_mem_req = 2'b00;
        e = rsp_q.pop_front();
        checks++; if (s_mem_ack !== e.ack) begin errors++; $display("FAIL wr_ack: got %b need %b", s_mem_ack, e.ack); end
        checks++; if (s_mem_rdata !== e.rdata) begin errors++; $display("FAIL wr_rdata: got %h need %h", s_mem_rdata, e.rdata); end
        checks++; if (s_mem_err !== e.err) begin errors++; $display("FAIL wr_err: got %b need %b", s_mem_err, e.err); end
        tick();
    endtask

    task automatic test_contention();
        bit             ok;
        int             g;
        int             gap;
        logic [C_AW-1:0] exp_addr;
        logic [C_N-1:0]  exp_ack;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        s_mem_addr[C_AW-1:0]      = 15'h0100;
        s_mem_addr[2*C_AW-1:C_AW] = 15'h0200;
        s_mem_wenable             = 2'b00;
        s_mem_req                 = 2'b11;
        for (int i = 0; i < 6; i++) grant_q.push_back(i % 2);
        for (int i = 0; i < 6; i++) begin
            wait_mreq(ok);
            checks++; if (!ok) begin errors++; $display("FAIL cont_req_timeout: txn %0d m_req %b need 1", i, m_mem_req); end
            g        = grant_q.pop_front();
            exp_addr = (g == 1) ? 15'h0200 : 15'h0100;
            exp_ack  = 2'b01 << g;
            checks++; if (m_mem_addr !== exp_addr) begin errors++; $display("FAIL cont_grant: txn %0d addr %h need %h", i, m_mem_addr, exp_addr); end
            m_mem_ack   = 1'b1;
            m_mem_rdata = 32'h1000 + i;
            tick();
            m_mem_ack = 1'b0;
            checks++; if (s_mem_ack !== exp_ack) begin errors++; $display("FAIL cont_ack: txn %0d got %b need %b", i, s_mem_ack, exp_ack); end
            checks++; if (s_mem_rdata !== 32'h1000 + i) begin errors++; $display("FAIL cont_rdata: txn %0d got %h need %h", i, s_mem_rdata, 32'h1000 + i); end
            if (i == 5) begin
                s_mem_req = 2'b00;
            end else begin
                gap = 0;
                do begin
                    tick();
                    gap++;
                end while (m_mem_req !== 1'b1 && gap < 10);
                checks++; if (gap != 2) begin errors++; $display("FAIL cont_gap: txn %0d got %0d cycles need 2", i, gap); end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit   ok;
        int   high;
        rsp_t e;
        s_mem_addr[C_AW-1:0] = 15'h0040;
        s_mem_wenable        = 2'b00;
        s_mem_req            = 2'b01;
        rsp_q.push_back('{ack: 2'b01, rdata: 32'h0, err: 1'b1});
        wait_mreq(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_req_timeout: got m_req %b need 1", m_mem_req); end
        high = 0;
        while (m_mem_req === 1'b1 && high < 20) begin
            high++;
            tick();
        end
        checks++; if (high != C_TO) begin errors++; $display("FAIL to_req_len: got %0d cycles need %0d", high, C_TO); end
        e = rsp_q.pop_front();
        checks++; if (s_mem_ack !== e.ack) begin errors++; $display("FAIL to_ack: got %b need %b", s_mem_ack, e.ack); end
        checks++; if (s_mem_err !== e.err) begin errors++; $display("FAIL to_err: got %b need %b", s_mem_err, e.err); end
        checks++; if (s_mem_rdata !== e.rdata) begin errors++; $display("FAIL to_rdata: got %h need %h", s_mem_rdata, e.rdata); end
        s_mem_req   = 2'b00;
        m_mem_ack   = 1'b1;
        m_mem_rdata = 32'hBAD0BAD0;
        tick();
        checks++; if (s_mem_ack !== 2'b00 || s_mem_err !== 1'b0) begin errors++; $display("FAIL to_done_clear: ack %b err %b need 00 0", s_mem_ack, s_mem_err); end
        tick();
        m_mem_ack = 1'b0;
        checks++; if (s_mem_ack !== 2'b00) begin errors++; $display("FAIL late_ack_ignored: got %b need 00", s_mem_ack); end
        checks++; if (m_mem_req !== 1'b0) begin errors++; $display("FAIL late_ack_req: got %b need 0", m_mem_req); end
        checks++; if (s_mem_rdata !== 32'h0) begin errors++; $display("FAIL late_ack_rdata: got %h need 0", s_mem_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit   ok;
        rsp_t e;
        s_mem_addr[C_AW-1:0]      = 15'h0300;
        s_mem_addr[2*C_AW-1:C_AW] = 15'h0301;
        s_mem_wenable             = 2'b00;
        s_mem_req                 = 2'b01;
        wait_mreq(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_req_timeout: got m_req %b need 1", m_mem_req); end
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (m_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b need 0", m_mem_req); end
        checks++; if (m_mem_addr !== '0) begin errors++; $display("FAIL rst_mid_addr: got %h need 0", m_mem_addr); end
        checks++; if (s_mem_ack !== 2'b00) begin errors++; $display("FAIL rst_mid_ack: got %b need 00", s_mem_ack); end
        checks++; if (s_mem_rdata !== '0) begin errors++; $display("FAIL rst_mid_rdata: got %h need 0", s_mem_rdata); end
        rst_n     = 1'b1;
        s_mem_req = 2'b11;
        rsp_q.push_back('{ack: 2'b01, rdata: 32'h00000001, err: 1'b0});
        tick();
        checks++; if (m_mem_req !== 1'b1) begin errors++; $display("FAIL rst_after_req: got %b need 1", m_mem_req); end
        checks++; if (m_mem_addr !== 15'h0300) begin errors++; $display("FAIL rst_priority: addr %h need 0300", m_mem_addr); end
        m_mem_ack   = 1'b1;
        m_mem_rdata = 32'h00000001;
        tick();
        m_mem_ack = 1'b0;
        s_mem_req = 2'b00;
        e = rsp_q.pop_front();
        checks++; if (s_mem_ack !== e.ack) begin errors++; $display("FAIL rst_after_ack: got %b need %b", s_mem_ack, e.ack); end
        tick();
        tick();
    endtask

    task automatic test_coincident();
        bit   ok;
        rsp_t e;
        s_mem_addr[2*C_AW-1:C_AW] = 15'h0123;
        s_mem_wenable             = 2'b00;
        s_mem_req                 = 2'b10;
        rsp_q.push_back('{ack: 2'b10, rdata: 32'hCAFEF00D, err: 1'b0});
        wait_mreq(ok);
        checks++; if (!ok) begin errors++; $display("FAIL co_req_timeout: got m_req %b need 1", m_mem_req); end
        for (int i = 0; i < C_TO - 1; i++) tick();
        checks++; if (m_mem_req !== 1'b1) begin errors++; $display("FAIL co_req_last: got %b need 1", m_mem_req); end
        m_mem_ack   = 1'b1;
        m_mem_rdata = 32'hCAFEF00D;
        tick();
        m_mem_ack = 1'b0;
        s_mem_req = 2'b00;
        e = rsp_q.pop_front();
        checks++; if (s_mem_ack !== e.ack) begin errors++; $display("FAIL co_ack: got %b need %b", s_mem_ack, e.ack); end
        checks++; if (s_mem_err !== e.err) begin errors++; $display("FAIL co_err: got %b need %b", s_mem_err, e.err); end
        checks++; if (s_mem_rdata !== e.rdata) begin errors++; $display("FAIL co_rdata: got %h need %h", s_mem_rdata, e.rdata); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_timeout();
        test_reset_mid_busy();
        test_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
